// File: rtl/instruction_fetch.sv
// Instruction fetch stage: a small Moore FSM that samples the program counter,
// issues one instruction memory read per loop, buffers the returned word for
// decode and pulses the program counter write enable with the incremented
// address. A fetch that never gets its acknowledge parks the stage in HALT
// with a sticky fault until reset.
module instruction_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] pcAddr,
    output logic        pcWrite,
    output logic [31:0] pcPlusOne,
    output logic        memReq,
    output logic [12:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] instr,
    output logic [12:0] instrPc,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        flush,
    output logic        fetchErr
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2,
        HALT   = 2'd3
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e      state_q,   state_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [12:0] reqAddr_q, reqAddr_d;
    logic [31:0] instr_q,   instr_d;
    logic [12:0] instrPc_q, instrPc_d;
    logic        valid_q,   valid_d;
    logic [12:0] next_q,    next_d;
    logic        err_q,     err_d;
    logic        capture;

    // Next-state, buffer update and Moore outputs (pcWrite also gated by flush)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reqAddr_d = reqAddr_q;
        instr_d   = instr_q;
        instrPc_d = instrPc_q;
        valid_d   = valid_q;
        next_d    = next_q;
        err_d     = err_q;
        capture   = 1'b0;
        memReq    = 1'b0;
        pcWrite   = 1'b0;

        case (state_q)
            LOAD: begin
                reqAddr_d = pcAddr;
                if (flush) begin
                    state_d = LOAD;
                    cnt_d   = 8'd0;
                end else if (!valid_q || instrReady) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                memReq = 1'b1;
                if (flush) begin
                    // In-flight request is abandoned; any same-cycle ack is dropped.
                    cnt_d   = 8'd0;
                    state_d = LOAD;
                end else if (memAck) begin
                    capture = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = COMMIT;
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                    if (cnt_d >= TIMEOUT_C) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            COMMIT: begin
                pcWrite = !flush;
                state_d = LOAD;
                if (flush) begin
                    cnt_d = 8'd0;
                end
            end
            default: begin
                // HALT: only reset leaves; flush is ignored here.
                state_d = HALT;
            end
        endcase

        // A fresh capture wins over a drain or flush on the same edge.
        if (capture) begin
            instr_d   = memData;
            instrPc_d = reqAddr_q;
            valid_d   = 1'b1;
            next_d    = 13'(reqAddr_q + 13'd1);
        end else if (flush && (state_q != HALT)) begin
            valid_d = 1'b0;
        end else if (valid_q && instrReady) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            cnt_q     <= 8'd0;
            reqAddr_q <= 13'd0;
            instr_q   <= 32'd0;
            instrPc_q <= 13'd0;
            valid_q   <= 1'b0;
            next_q    <= 13'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reqAddr_q <= reqAddr_d;
            instr_q   <= instr_d;
            instrPc_q <= instrPc_d;
            valid_q   <= valid_d;
            next_q    <= next_d;
            err_q     <= err_d;
        end
    end

    assign memAddr    = reqAddr_q;
    assign pcPlusOne  = {19'd0, next_q};
    assign instr      = instr_q;
    assign instrPc    = instrPc_q;
    assign instrValid = valid_q;
    assign fetchErr   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a randomized run,
// all checked against a transaction-level reference model of the fetch loop.
module tb_instruction_fetch;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic [12:0] pcAddr;
    logic        pcWrite;
    logic [31:0] pcPlusOne;
    logic        memReq;
    logic [12:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic [31:0] instr;
    logic [12:0] instrPc;
    logic        instrValid;
    logic        instrReady;
    logic        flush;
    logic        fetchErr;

    int n_cmp;
    int n_bad;

    instruction_fetch #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcAddr     (pcAddr),
        .pcWrite    (pcWrite),
        .pcPlusOne  (pcPlusOne),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData),
        .instr      (instr),
        .instrPc    (instrPc),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .flush      (flush),
        .fetchErr   (fetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what phase of the fetch loop we are in, plus the
    // architecturally visible buffer contents.
    localparam int PH_SAMPLE  = 0;   // sampling the PC, waiting for a free slot
    localparam int PH_REQUEST = 1;   // read outstanding
    localparam int PH_WRITEPC = 2;   // handing the next PC back
    localparam int PH_DEAD    = 3;   // timed out

    int ph;
    int m_addr;
    int m_wait;
    int m_next;
    int m_ipc;
    bit m_valid;
    bit m_err;
    logic [31:0] m_instr;

    task automatic model_reset();
        ph = PH_SAMPLE; m_addr = 0; m_wait = 0; m_next = 0; m_ipc = 0;
        m_valid = 0; m_err = 0; m_instr = 32'd0;
    endtask

    task automatic model_edge();
        int nph;
        bit got;
        bit was_valid;
        nph = ph; got = 0; was_valid = m_valid;
        if (ph == PH_SAMPLE) begin
            m_addr = int'(pcAddr);
            if (!flush && (!was_valid || instrReady)) nph = PH_REQUEST;
        end else if (ph == PH_REQUEST) begin
            if (flush) begin
                m_wait = 0; nph = PH_SAMPLE;
            end else if (memAck) begin
                got = 1; m_wait = 0; nph = PH_WRITEPC;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait >= TO) begin m_err = 1; nph = PH_DEAD; end
            end
        end else if (ph == PH_WRITEPC) begin
            nph = PH_SAMPLE;
        end
        if (got) begin
            m_instr = memData; m_ipc = m_addr; m_next = (m_addr + 1) % 8192; m_valid = 1;
        end else if (flush && ph != PH_DEAD) begin
            m_valid = 0;
        end else if (was_valid && instrReady) begin
            m_valid = 0;
        end
        ph = nph;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".memReq"},     32'(memReq),     32'(ph == PH_REQUEST));
        chk({tag, ".memAddr"},    32'(memAddr),    32'(m_addr));
        chk({tag, ".pcWrite"},    32'(pcWrite),    32'(ph == PH_WRITEPC && !flush));
        chk({tag, ".pcPlusOne"},  pcPlusOne,       32'(m_next));
        chk({tag, ".instrValid"}, 32'(instrValid), 32'(m_valid));
        chk({tag, ".instr"},      instr,           m_instr);
        chk({tag, ".instrPc"},    32'(instrPc),    32'(m_ipc));
        chk({tag, ".fetchErr"},   32'(fetchErr),   32'(m_err));
    endtask

    task automatic drive(input logic [12:0] pc, input logic ack, input logic [31:0] d,
                         input logic rdy, input logic fl);
        pcAddr = pc; memAck = ack; memData = d; instrReady = rdy; flush = fl;
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        drive(13'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic fetch, ack one cycle after the request
        drive(13'h0010, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle("basic.load");
        chk("basic.memReq", 32'(memReq), 32'd1);
        chk("basic.memAddr", 32'(memAddr), 32'h10);
        cycle("basic.wait");
        drive(13'h0010, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        cycle("basic.ack");
        chk("basic.instr", instr, 32'hA5A5_0001);
        chk("basic.instrPc", 32'(instrPc), 32'h10);
        chk("basic.pcWrite", 32'(pcWrite), 32'd1);
        chk("basic.pcPlusOne", pcPlusOne, 32'h0000_0011);
        drive(13'h0020, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle("basic.commit");
        chk("basic.pcWrite_drop", 32'(pcWrite), 32'd0);

        // Decode stalls: stay in LOAD holding the buffered word
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.memReq", 32'(memReq), 32'd0);
            chk("stall.instr", instr, 32'hA5A5_0001);
        end
        drive(13'h0020, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle("stall.release");
        chk("stall.resume_memReq", 32'(memReq), 32'd1);
        chk("stall.drained", 32'(instrValid), 32'd0);
        drive(13'h0020, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        cycle("stall.ack");
        drive(13'h1FFF, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle("stall.commit");

        // Address wrap at the top of the 13-bit space
        cycle("wrap.load");
        drive(13'h1FFF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cycle("wrap.ack");
        chk("wrap.pcPlusOne", pcPlusOne, 32'h0000_0000);
        chk("wrap.instrPc", 32'(instrPc), 32'h1FFF);
        drive(13'h0055, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle("wrap.commit");

        // Flush coinciding with the acknowledge
        cycle("flush.load");
        drive(13'h0055, 1'b1, 32'hCAFE_0000, 1'b1, 1'b1);
        cycle("flush.ack");
        chk("flush.instrValid", 32'(instrValid), 32'd0);
        drive(13'h0055, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("flush.in_load", 32'(memReq), 32'd0);
        cycle("flush.after");
        chk("flush.pcWrite", 32'(pcWrite), 32'd0);

        // Reset while the request is outstanding
        pulse_reset();
        chk("rstfetch.memReq", 32'(memReq), 32'd0);
        drive(13'h0077, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle("rstfetch.load");
        chk("rstfetch.memReq_next", 32'(memReq), 32'd1);
        chk("rstfetch.memAddr", 32'(memAddr), 32'h77);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (ph == PH_DEAD || $urandom_range(0, 149) == 0) begin
                pulse_reset();
            end
            drive(13'($urandom), ($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            cycle("rand");
        end

        // Timeout into HALT
        pulse_reset();
        drive(13'h0123, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle("to.load");
        for (int i = 0; i < TO; i++) begin
            chk("to.pending", 32'(fetchErr), 32'd0);
            cycle("to.fetch");
        end
        chk("to.fetchErr", 32'(fetchErr), 32'd1);
        chk("to.memReq", 32'(memReq), 32'd0);
        drive(13'h0123, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle("to.halt_flush");
        chk("to.sticky", 32'(fetchErr), 32'd1);
        chk("to.halt_memReq", 32'(memReq), 32'd0);
        drive(13'h0123, 1'b0, 32'd0, 1'b1, 1'b0);
        pulse_reset();
        chk("to.cleared", 32'(fetchErr), 32'd0);
        cycle("to.restart");
        chk("to.restart_memReq", 32'(memReq), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
